// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer: channel count,
// select width, FSM state encoding and the select-to-index helper.
package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  typedef enum logic {
    S_IDLE   = ST_IDLE,
    S_LOCKED = ST_LOCKED
  } state_e;

  // {a,b} maps straight onto the channel number, matching the 4:1 mux.
  function automatic logic [SEL_W-1:0] sel_idx(input logic a, input logic b);
    return {a, b};
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output register for a single demux channel. A filled entry holds
// its data/last stable until the downstream side takes it; a fill arriving in
// the same cycle as a drain replaces the entry and keeps valid asserted.
module demux_slot
  import demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              fill_last,
  input  logic              drain_ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              last
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;

  // Next-state: drain clears valid, fill (taking priority) loads a new beat.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (valid_q && drain_ready) begin
      valid_d = 1'b0;
    end
    if (fill) begin
      valid_d = 1'b1;
      data_d  = fill_data;
      last_d  = fill_last;
    end
  end

  // Entry registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign last  = last_q;

endmodule

// File: rtl/demux1to4_stream.sv
// Packet-aware 1-to-4 stream demultiplexer. The select {a,b} is sampled on the
// first beat of a packet and held until the last beat; each channel owns a
// one-entry output register with its own valid/ready handshake.
// Optional feature: define DEMUX_SEL_CHK_EN to build a sticky sel_err flag
// that fires when {a,b} changes on an accepted beat inside a locked packet.
module demux1to4_stream
  import demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_a,
  input  logic                     in_b,
  input  logic                     in_last,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_last,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic                     sel_err
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   lock_q, lock_d;
  logic [SEL_W-1:0]   in_sel;
  logic [SEL_W-1:0]   ch;
  logic               accept;
  logic [NUM_CH-1:0]  fill;

  // Route: pick the live select when idle, the locked one mid-packet, and
  // offer the beat only if that channel's slot is free or draining now.
  always_comb begin
    in_sel   = sel_idx(in_a, in_b);
    ch       = (state_q == S_IDLE) ? in_sel : lock_q;
    in_ready = ~out_valid[ch] | out_ready[ch];
    accept   = in_valid & in_ready;
    fill     = '0;
    fill[ch] = accept;
  end

  // Packet FSM next-state: lock the select on a non-final first beat,
  // release it when the last beat is accepted.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    case (state_q)
      S_IDLE: begin
        if (accept && !in_last) begin
          state_d = S_LOCKED;
          lock_d  = in_sel;
        end
      end
      S_LOCKED: begin
        if (accept && in_last) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and select-lock registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .fill        (fill[k]),
      .fill_data   (in_data),
      .fill_last   (in_last),
      .drain_ready (out_ready[k]),
      .valid       (out_valid[k]),
      .data        (out_data[k*DATA_W +: DATA_W]),
      .last        (out_last[k])
    );
  end

`ifdef DEMUX_SEL_CHK_EN
  logic sel_err_q, sel_err_d;

  // Sticky flag: any accepted mid-packet beat whose select disagrees with the lock.
  always_comb begin
    sel_err_d = sel_err_q;
    if (accept && (state_q == S_LOCKED) && (in_sel != lock_q)) begin
      sel_err_d = 1'b1;
    end
  end

  // Error flag register, only cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_demux1to4_stream.sv
// Directed testbench for demux1to4_stream: single-beat routing, locked
// multi-beat packets, per-channel back-pressure, independent channels,
// mid-packet reset and the optional select-change error flag.
module tb_demux1to4_stream;

  localparam int DATA_W = 8;

`ifdef DEMUX_SEL_CHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic                 clk;
  logic                 rst_n;
  logic [DATA_W-1:0]    in_data;
  logic                 in_a;
  logic                 in_b;
  logic                 in_last;
  logic                 in_valid;
  logic                 in_ready;
  logic [4*DATA_W-1:0]  out_data;
  logic [3:0]           out_last;
  logic [3:0]           out_valid;
  logic [3:0]           out_ready;
  logic                 sel_err;

  int passed = 0;
  int total  = 0;

  demux1to4_stream #(
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] d, input logic [1:0] ab, input logic lst, input logic vld);
    in_data  = d;
    in_a     = ab[1];
    in_b     = ab[0];
    in_last  = lst;
    in_valid = vld;
  endtask

  function automatic logic [7:0] slot(input int k);
    return out_data[k*DATA_W +: DATA_W];
  endfunction

  initial begin
    rst_n     = 1'b0;
    out_ready = 4'hF;
    drive(8'h00, 2'b00, 1'b0, 1'b0);

    // Reset state
    #12;
    chk("rst_valid", out_valid, 4'h0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_last", out_last, 4'h0);
    chk("rst_err", sel_err, 1'b0);
    rst_n = 1'b1;
    tick();

    // 1) Single-beat packets to each channel, back to back
    for (int k = 0; k < 4; k++) begin
      drive(8'hA0 + 8'(k), 2'(k), 1'b1, 1'b1);
      #1;
      chk("t1_in_ready", in_ready, 1'b1);
      tick();
      chk("t1_valid", out_valid, 4'b0001 << k);
      chk("t1_data", slot(k), 8'hA0 + 8'(k));
      chk("t1_last", out_last[k], 1'b1);
    end
    drive(8'h00, 2'b00, 1'b0, 1'b0);
    tick();
    chk("t1_drained", out_valid, 4'h0);

    // 2) Three-beat packet locked to ch2 while a/b wander
    drive(8'h11, 2'b10, 1'b0, 1'b1);
    tick();
    chk("t2_b1_valid", out_valid, 4'b0100);
    chk("t2_b1_data", slot(2), 8'h11);
    chk("t2_b1_last", out_last[2], 1'b0);
    drive(8'h22, 2'b01, 1'b0, 1'b1);
    tick();
    chk("t2_b2_valid", out_valid, 4'b0100);
    chk("t2_b2_data", slot(2), 8'h22);
    chk("t6_err_set", sel_err, EXP_ERR);
    drive(8'h33, 2'b11, 1'b1, 1'b1);
    tick();
    chk("t2_b3_valid", out_valid, 4'b0100);
    chk("t2_b3_data", slot(2), 8'h33);
    chk("t2_b3_last", out_last[2], 1'b1);
    drive(8'h00, 2'b00, 1'b0, 1'b0);
    tick();
    chk("t2_drained", out_valid, 4'h0);
    chk("t6_err_sticky", sel_err, EXP_ERR);

    // 3) ch1 stalled: first beat held, second beat back-pressured
    out_ready = 4'b1101;
    drive(8'h55, 2'b01, 1'b1, 1'b1);
    tick();
    chk("t3_first_valid", out_valid, 4'b0010);
    chk("t3_first_data", slot(1), 8'h55);
    drive(8'h66, 2'b01, 1'b1, 1'b1);
    #1;
    chk("t3_ready_low", in_ready, 1'b0);
    tick();
    chk("t3_hold_data", slot(1), 8'h55);
    chk("t3_hold_valid", out_valid, 4'b0010);
    chk("t3_still_low", in_ready, 1'b0);
    out_ready = 4'b1111;
    #1;
    chk("t3_ready_high", in_ready, 1'b1);
    tick();
    chk("t3_replace_valid", out_valid, 4'b0010);
    chk("t3_replace_data", slot(1), 8'h66);
    drive(8'h00, 2'b00, 1'b0, 1'b0);
    tick();
    chk("t3_drained", out_valid, 4'h0);

    // 4) ch0 stalled while a packet flows to ch3
    out_ready = 4'b1110;
    drive(8'h77, 2'b00, 1'b1, 1'b1);
    tick();
    chk("t4_ch0_fill", slot(0), 8'h77);
    drive(8'h88, 2'b11, 1'b0, 1'b1);
    #1;
    chk("t4_ready_ch3", in_ready, 1'b1);
    tick();
    chk("t4_b1_valid", out_valid, 4'b1001);
    chk("t4_b1_data", slot(3), 8'h88);
    drive(8'h99, 2'b11, 1'b1, 1'b1);
    tick();
    chk("t4_b2_data", slot(3), 8'h99);
    chk("t4_b2_last", out_last[3], 1'b1);
    chk("t4_ch0_stable", slot(0), 8'h77);
    drive(8'h00, 2'b00, 1'b0, 1'b0);
    tick();
    chk("t4_ch3_drained", out_valid, 4'b0001);
    out_ready = 4'hF;
    tick();
    chk("t4_all_drained", out_valid, 4'h0);

    // 5) Reset in the middle of a packet locked to ch1
    out_ready = 4'h0;
    drive(8'hAB, 2'b01, 1'b0, 1'b1);
    tick();
    chk("t5_pre_valid", out_valid, 4'b0010);
    drive(8'h00, 2'b00, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", out_valid, 4'h0);
    chk("t5_rst_data", out_data, 32'h0);
    chk("t5_rst_err", sel_err, 1'b0);
    #3;
    rst_n     = 1'b1;
    out_ready = 4'hF;
    drive(8'hC2, 2'b10, 1'b1, 1'b1);
    #1;
    chk("t5_ready", in_ready, 1'b1);
    tick();
    chk("t5_route_valid", out_valid, 4'b0100);
    chk("t5_route_data", slot(2), 8'hC2);
    drive(8'h00, 2'b00, 1'b0, 1'b0);
    tick();
    chk("t5_drained", out_valid, 4'h0);
    chk("t5_err_clear", sel_err, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
